// File: rtl/pi_pkg.sv
// pi_pkg: shared defaults, width helpers and FSM states for the pi estimator
package pi_pkg;
  localparam int DEF_COORD_W = 9;
  localparam int DEF_CENTER = 236;
  localparam int DEF_RADIUS = 236;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_FRAC_W = 12;
  typedef enum logic [2:0] {S_IDLE, S_SQUARE, S_TALLY, S_DIVIDE, S_DONE} state_e;
  function automatic int radius_sq(int r);
    return r * r;
  endfunction
  function automatic int d2_w(int coord_w);
    return 2 * coord_w + 3;
  endfunction
  function automatic int est_w(int frac_w);
    return frac_w + 3;
  endfunction
  function automatic int dividend_w(int cnt_w, int frac_w);
    return cnt_w + frac_w + 2;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per cycle, MSB first
module seq_divider #(
  parameter int DVD_W = 34,
  parameter int DVS_W = 20,
  parameter int Q_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);
  localparam int CB = $clog2(Q_W + 1);
  logic [DVS_W-1:0] rem_q, dvs_q;
  logic [Q_W-1:0] sh_q;
  logic [CB-1:0] cnt_q;
  logic busy_q, done_q, fits;
  logic [DVS_W:0] trial;
  always_comb begin
    trial = {rem_q, sh_q[Q_W-1]};
    fits = trial >= {1'b0, dvs_q};
  end
  // Remainder seeds from the dividend bits above the quotient window; the caller keeps them below the divisor.
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      rem_q <= '0;
      dvs_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q <= DVS_W'(dividend[DVD_W-1:Q_W]);
      sh_q <= dividend[Q_W-1:0];
      dvs_q <= divisor;
      cnt_q <= CB'(Q_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= fits ? DVS_W'(trial - {1'b0, dvs_q}) : DVS_W'(trial);
      sh_q <= {sh_q[Q_W-2:0], fits};
      cnt_q <= cnt_q - CB'(1);
      busy_q <= cnt_q != CB'(1);
      done_q <= cnt_q == CB'(1);
    end else begin
      done_q <= 1'b0;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quotient = sh_q;
endmodule

// File: rtl/pi_estimator.sv
// pi_estimator: Monte-Carlo inside/total tally with a sequential Q3.FRAC_W estimate of 4*inside/total
module pi_estimator
  import pi_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int CENTER = DEF_CENTER,
  parameter int RADIUS = DEF_RADIUS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] sample_x,
  input  logic [COORD_W-1:0] sample_y,
  output logic               sample_ready,
  output logic [CNT_W-1:0]   inside_count,
  output logic [CNT_W-1:0]   total_count,
  output logic [FRAC_W+2:0]  pi_est,
  output logic               est_valid,
  output logic               saturated
);
  localparam int DX_W = COORD_W + 1;
  localparam int D2_W = d2_w(COORD_W);
  localparam int EST_W = est_w(FRAC_W);
  localparam int DIVIDEND_W = dividend_w(CNT_W, FRAC_W);
  localparam int RADIUS_SQ = radius_sq(RADIUS);
  state_e state_q;
  logic signed [DX_W-1:0] dx_q, dy_q, dx_d, dy_d;
  logic signed [2*DX_W-1:0] sqx, sqy;
  logic [D2_W-1:0] d2_q, d2_d;
  logic [CNT_W-1:0] inside_q, total_q, inside_d, total_d;
  logic [EST_W-1:0] pi_q, quotient;
  logic est_valid_q, sat_q, accept, div_start, div_busy, div_done;
  always_comb begin
    dx_d = {1'b0, sample_x} - DX_W'(CENTER);
    dy_d = {1'b0, sample_y} - DX_W'(CENTER);
    sqx = dx_q * dx_q;
    sqy = dy_q * dy_q;
    d2_d = {1'b0, sqx} + {1'b0, sqy};
    inside_d = inside_q + CNT_W'(d2_q <= D2_W'(RADIUS_SQ));
    total_d = total_q + CNT_W'(1);
    sample_ready = state_q == S_IDLE && !div_busy;
    accept = sample_valid && sample_ready;
    div_start = state_q == S_TALLY && !sat_q;
  end
  // Saturated samples still pass the handshake and pipeline but are dropped at the tally.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q <= S_IDLE;
      dx_q <= '0;
      dy_q <= '0;
      d2_q <= '0;
      inside_q <= '0;
      total_q <= '0;
      pi_q <= '0;
      est_valid_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      est_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          dx_q <= dx_d;
          dy_q <= dy_d;
          state_q <= S_SQUARE;
        end
        S_SQUARE: begin
          d2_q <= d2_d;
          state_q <= S_TALLY;
        end
        S_TALLY: begin
          state_q <= sat_q ? S_IDLE : S_DIVIDE;
          if (!sat_q) begin
            inside_q <= inside_d;
            total_q <= total_d;
            sat_q <= &total_d;
          end
        end
        S_DIVIDE: if (div_done) begin
          pi_q <= quotient;
          est_valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  seq_divider #(
    .DVD_W(DIVIDEND_W),
    .DVS_W(CNT_W),
    .Q_W(EST_W)
  ) u_div (
    .clk(clk),
    .reset(reset),
    .abort(clear),
    .start(div_start),
    .dividend({inside_d, {(FRAC_W+2){1'b0}}}),
    .divisor(total_d),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient)
  );
  assign inside_count = inside_q;
  assign total_count = total_q;
  assign pi_est = pi_q;
  assign est_valid = est_valid_q;
  assign saturated = sat_q;
endmodule

// File: tb/tb_pi_estimator.sv
// tb_pi_estimator: directed stimulus on a default and a CNT_W=3 instance, checked against a per-cycle behavioural model
module tb_pi_estimator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr[2];
  logic vld[2];
  logic [8:0] sx[2];
  logic [8:0] sy[2];
  logic rdy0, est0, sat0, rdy1, est1, sat1;
  logic [19:0] ins0, tot0;
  logic [2:0] ins1, tot1;
  logic [14:0] pi0, pi1;
  logic rdy_w[2], est_w[2], sat_w[2];
  logic [19:0] ins_w[2], tot_w[2];
  logic [14:0] pi_w[2];
  int n_tests = 0;
  int n_fail = 0;
  int m_ins[2], m_tot[2], m_pi[2], m_age[2];
  bit m_est[2], m_sat[2], m_busy[2], m_flag[2], m_acc;
  int max_tot[2] = '{1048575, 7};
  bit started = 1'b0;

  always #5 clk = ~clk;

  pi_estimator dut0 (
    .clk(clk), .reset(rst), .clear(clr[0]), .sample_valid(vld[0]),
    .sample_x(sx[0]), .sample_y(sy[0]), .sample_ready(rdy0),
    .inside_count(ins0), .total_count(tot0), .pi_est(pi0),
    .est_valid(est0), .saturated(sat0)
  );

  pi_estimator #(.CNT_W(3)) dut1 (
    .clk(clk), .reset(rst), .clear(clr[1]), .sample_valid(vld[1]),
    .sample_x(sx[1]), .sample_y(sy[1]), .sample_ready(rdy1),
    .inside_count(ins1), .total_count(tot1), .pi_est(pi1),
    .est_valid(est1), .saturated(sat1)
  );

  always_comb begin
    rdy_w[0] = rdy0;
    rdy_w[1] = rdy1;
    est_w[0] = est0;
    est_w[1] = est1;
    sat_w[0] = sat0;
    sat_w[1] = sat1;
    ins_w[0] = ins0;
    ins_w[1] = 20'(ins1);
    tot_w[0] = tot0;
    tot_w[1] = 20'(tot1);
    pi_w[0] = pi0;
    pi_w[1] = pi1;
  end

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_circle(int x, int y);
    int dx = x - 236;
    int dy = y - 236;
    return dx * dx + dy * dy <= 236 * 236;
  endfunction

  // Model: an accepted sample tallies 2 edges later, publishes its estimate at 18, frees the block at 19.
  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!rst || clr[i]) begin
        m_ins[i] = 0;
        m_tot[i] = 0;
        m_pi[i] = 0;
        m_age[i] = 0;
        m_est[i] = 0;
        m_sat[i] = 0;
        m_busy[i] = 0;
      end else begin
        m_acc = vld[i] && !m_busy[i];
        m_est[i] = 0;
        if (m_busy[i]) begin
          m_age[i]++;
          if (m_age[i] == 2) begin
            if (m_sat[i]) m_busy[i] = 0;
            else begin
              m_tot[i]++;
              m_ins[i] += int'(m_flag[i]);
              if (m_tot[i] == max_tot[i]) m_sat[i] = 1;
            end
          end
          if (m_age[i] == 18) begin
            m_pi[i] = int'((longint'(m_ins[i]) * 4 * 4096) / m_tot[i]);
            m_est[i] = 1;
          end
          if (m_age[i] == 19) m_busy[i] = 0;
        end
        if (m_acc) begin
          m_busy[i] = 1;
          m_age[i] = 0;
          m_flag[i] = in_circle(int'(sx[i]), int'(sy[i]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model d%0d ready", i), rdy_w[i], !m_busy[i]);
        chk($sformatf("model d%0d est_valid", i), est_w[i], m_est[i]);
        chk($sformatf("model d%0d saturated", i), sat_w[i], m_sat[i]);
        chk($sformatf("model d%0d inside", i), ins_w[i], m_ins[i]);
        chk($sformatf("model d%0d total", i), tot_w[i], m_tot[i]);
        chk($sformatf("model d%0d pi_est", i), pi_w[i], m_pi[i]);
      end
    end
  end

  task automatic send(int i, int x, int y);
    int n = 0;
    while (!rdy_w[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("d%0d ready wait", i), rdy_w[i], 1);
    vld[i] = 1'b1;
    sx[i] = 9'(x);
    sy[i] = 9'(y);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic counts(int i, string nm, int e_in, int e_tot);
    chk({nm, " inside"}, ins_w[i], e_in);
    chk({nm, " total"}, tot_w[i], e_tot);
  endtask

  task automatic wait_est(int i, string nm, int e_pi);
    int n = 0;
    while (!est_w[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " est_valid"}, est_w[i], 1);
    chk({nm, " pi_est"}, pi_w[i], e_pi);
    @(negedge clk);
  endtask

  task automatic sample(int i, string nm, int x, int y, int e_in, int e_tot, int e_pi);
    send(i, x, y);
    repeat (2) @(negedge clk);
    counts(i, nm, e_in, e_tot);
    wait_est(i, nm, e_pi);
  endtask

  task automatic pulse_clear(int i);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b0;
      vld[i] = 1'b0;
      sx[i] = '0;
      sy[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    counts(0, "reset", 0, 0);
    chk("reset pi_est", pi_w[0], 0);
    chk("reset ready", rdy_w[0], 1);
    chk("reset est_valid", est_w[0], 0);
    chk("reset saturated", sat_w[0], 0);
    send(0, 236, 236);
    for (int a = 1; a <= 19; a++) begin
      @(negedge clk);
      chk($sformatf("centre ready @%0d", a), rdy_w[0], a >= 19);
      chk($sformatf("centre est @%0d", a), est_w[0], a == 18);
      if (a == 2) counts(0, "centre", 1, 1);
      if (a == 18) chk("centre pi_est", pi_w[0], 15'h4000);
    end
    sample(0, "outside", 0, 0, 1, 2, 15'h2000);
    sample(0, "boundary", 472, 236, 2, 3, 15'h2AAA);
    pulse_clear(0);
    counts(0, "clear", 0, 0);
    chk("clear pi_est", pi_w[0], 0);
    sample(0, "just outside", 473, 236, 0, 1, 15'h0000);
    sample(0, "trunc centre", 236, 236, 1, 2, 15'h2000);
    sample(0, "trunc corner", 0, 511, 1, 3, 15'h1555);
    pulse_clear(0);
    send(0, 236, 236);
    repeat (7) @(negedge clk);
    pulse_clear(0);
    counts(0, "mid-divide clear", 0, 0);
    chk("mid-divide clear pi_est", pi_w[0], 0);
    for (int a = 0; a < 15; a++) begin
      chk("mid-divide clear no est", est_w[0], 0);
      @(negedge clk);
    end
    sample(0, "after clear", 236, 236, 1, 1, 15'h4000);
    clr[0] = 1'b1;
    vld[0] = 1'b1;
    sx[0] = 9'd236;
    sy[0] = 9'd236;
    @(negedge clk);
    clr[0] = 1'b0;
    vld[0] = 1'b0;
    chk("clear+valid ready", rdy_w[0], 1);
    repeat (2) @(negedge clk);
    counts(0, "clear+valid", 0, 0);
    vld[0] = 1'b1;
    sx[0] = 9'd0;
    sy[0] = 9'd0;
    repeat (30) @(negedge clk);
    vld[0] = 1'b0;
    repeat (25) @(negedge clk);
    counts(0, "held valid", 0, 2);
    for (int k = 1; k <= 9; k++) begin
      send(1, 236, 236);
      repeat (2) @(negedge clk);
      if (k <= 7) begin
        counts(1, $sformatf("sat #%0d", k), k, k);
        chk($sformatf("sat #%0d saturated", k), sat_w[1], k == 7);
        wait_est(1, $sformatf("sat #%0d", k), 15'h4000);
      end else begin
        counts(1, $sformatf("sat #%0d", k), 7, 7);
        chk($sformatf("sat #%0d saturated", k), sat_w[1], 1);
        chk($sformatf("sat #%0d pi_est", k), pi_w[1], 15'h4000);
        repeat (20) begin
          chk($sformatf("sat #%0d no est", k), est_w[1], 0);
          @(negedge clk);
        end
      end
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pi_estimator.md
Name: pi_estimator

Overview:
- Monte-Carlo π accumulator, downstream of the two 9-bit coordinate LFSRs and in parallel with the pixel-memory write port.
- Each accepted (x, y) sample is classified as inside or outside the 472×472 circle (centre 236,236, radius 236), and inside/total tallies are kept.
- After every sample, a fixed-point estimate π ≈ 4·inside/total is recomputed with a multi-cycle restoring divider.
- Results feed the on-screen readout and status logic.

Parameters:
- COORD_W, 9: width of sample_x / sample_y.
- CENTER, 236: circle centre on both axes.
- RADIUS, 236: circle radius; the inside test uses RADIUS².
- CNT_W, 20: width of the inside/total counters.
- FRAC_W, 12: fractional bits of pi_est. Format is unsigned Q3.FRAC_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- clear  input  1  synchronous tally clear, active-high.
- sample_valid  input  1  a sample is offered.
- sample_x  input  COORD_W  sample X coordinate.
- sample_y  input  COORD_W  sample Y coordinate.
- sample_ready  output  1  block can accept a sample this cycle.
- inside_count  output  CNT_W  number of accepted samples classified inside.
- total_count  output  CNT_W  number of accepted samples.
- pi_est  output  FRAC_W+3  latest estimate, Q3.FRAC_W.
- est_valid  output  1  one-cycle pulse when pi_est updates.
- saturated  output  1  total_count has reached its maximum.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - inside_count, total_count, pi_est = 0.
  - est_valid = 0, saturated = 0, sample_ready = 1 on the next cycle.
- Handshake:
  - A sample is accepted on any posedge with sample_valid && sample_ready.
  - sample_ready = 1 only in IDLE; the block holds at most one sample in flight.
- FSM states: IDLE → SQUARE → TALLY → DIVIDE → DONE → IDLE.
  - IDLE: on accept, register dx = x − CENTER and dy = y − CENTER. These are signed, COORD_W+1 bits.
  - SQUARE (1 cycle): register d2 = dx² + dy², 2·COORD_W+3 bits unsigned.
  - TALLY (1 cycle):
    - inside = (d2 ≤ RADIUS²); the boundary counts as inside.
    - total_count += 1; inside_count += inside.
    - Load the divider with dividend = inside_count_new << (FRAC_W+2) and divisor = total_count_new.
  - DIVIDE: exactly FRAC_W+3 cycles, one restoring quotient bit per cycle, MSB first. Result is truncated (floor).
  - DONE (1 cycle): pi_est ← quotient; est_valid = 1 for this cycle only.
- Latency:
  - Counts are visible 2 cycles after the accept edge.
  - est_valid is asserted FRAC_W+6 cycles after the accept edge (18 cycles at defaults).
- Divide-by-zero cannot occur, since total ≥ 1 in TALLY. A 4.0 result (all samples inside) must be representable; hence 3 integer bits.
- Saturation:
  - When total_count == 2^CNT_W − 1, saturated goes high and stays high until reset or clear.
  - While saturated, samples are still accepted (sample_ready stays 1 in IDLE) but discarded in TALLY. Counters and pi_est freeze, and est_valid is not pulsed.
- Clear:
  - clear has priority over everything except reset, in any state including mid-DIVIDE.
  - On the next edge: FSM = IDLE, counters = 0, pi_est = 0, saturated = 0.
  - Any in-flight sample is lost, and no est_valid is pulsed for it.
- A simultaneous clear and sample_valid discards the sample.

Decomposition:
- Package pi_pkg holds:
  - the FSM state enum;
  - CENTER and RADIUS_SQ = RADIUS*RADIUS;
  - derived widths (D2_W, EST_W = FRAC_W+3, DIVIDEND_W = CNT_W+FRAC_W+2).
- Sub-module seq_divider: parameterised unsigned restoring divider.
  - Interface: start, busy, done, dividend, divisor, quotient.
  - One quotient bit per cycle; the iteration count is a parameter.
  - Has its own clk/reset, plus an abort input driven by clear.

Test Plan:
- Reset: assert reset=0 for 3 cycles, then release → counts=0, pi_est=0x0000, sample_ready=1, est_valid=0, saturated=0.
- Centre sample: (236,236) → after 2 cycles inside=1, total=1; est_valid exactly 18 cycles after accept with pi_est=0x4000 (4.0); sample_ready low for cycles 1–18.
- Outside, then boundary:
  - Then (0,0) → inside=1, total=2, pi_est=0x2000.
  - Then (472,236) → counted inside (d2 == RADIUS²) → inside=2, total=3, pi_est=0x2AAA.
- Just outside and truncation: fresh run with (473,236), (236,236), (0,511) → inside=1, total=3, pi_est=0x1555 (4/3 truncated).
- Clear mid-divide: accept (236,236), pulse clear 8 cycles after accept → next cycle counts=0, pi_est=0, no est_valid pulse; a following (236,236) yields pi_est=0x4000.
- Saturation with CNT_W=3: feed 9 centre samples → total sticks at 7, saturated=1 after the 7th, the 8th and 9th are accepted but produce no est_valid, and pi_est stays 0x4000.
